// File: rtl/nb_sc_mapper.sv
// Purpose : maps a bank of 12 NB-IoT tones (selected by ISC) onto a 128-bin IFFT
//           input frame centred on DC, streaming one bin per beat.
// Latency : bin 0 is presented the cycle after accept; one IDLE cycle separates frames.
// Backpressure: out_* hold while out_valid && !out_ready; in_ready is low for the whole frame.
// Ports   : clk, reset (sync, active-low); in_valid/in_ready + ISC + in_rl0..11/in_img0..11
//           input bank; out_valid/out_ready + out_re/out_im/out_idx/out_last output
//           stream; isc_err flags an out-of-range ISC latched at the last accept.
module nb_sc_mapper #(
  parameter int DW   = 32,
  parameter int NSC  = 12,
  parameter int NFFT = 128
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4:0]              ISC,
  input  logic [DW-1:0]           in_rl0,
  input  logic [DW-1:0]           in_rl1,
  input  logic [DW-1:0]           in_rl2,
  input  logic [DW-1:0]           in_rl3,
  input  logic [DW-1:0]           in_rl4,
  input  logic [DW-1:0]           in_rl5,
  input  logic [DW-1:0]           in_rl6,
  input  logic [DW-1:0]           in_rl7,
  input  logic [DW-1:0]           in_rl8,
  input  logic [DW-1:0]           in_rl9,
  input  logic [DW-1:0]           in_rl10,
  input  logic [DW-1:0]           in_rl11,
  input  logic [DW-1:0]           in_img0,
  input  logic [DW-1:0]           in_img1,
  input  logic [DW-1:0]           in_img2,
  input  logic [DW-1:0]           in_img3,
  input  logic [DW-1:0]           in_img4,
  input  logic [DW-1:0]           in_img5,
  input  logic [DW-1:0]           in_img6,
  input  logic [DW-1:0]           in_img7,
  input  logic [DW-1:0]           in_img8,
  input  logic [DW-1:0]           in_img9,
  input  logic [DW-1:0]           in_img10,
  input  logic [DW-1:0]           in_img11,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DW-1:0]           out_re,
  output logic [DW-1:0]           out_im,
  output logic [$clog2(NFFT)-1:0] out_idx,
  output logic                    out_last,
  output logic                    isc_err
);

  localparam int CW = $clog2(NFFT);
  localparam logic [CW-1:0] LO_MAX = CW'(NSC / 2 - 1);   // last positive-frequency bin
  localparam logic [CW-1:0] HI_MIN = CW'(NFFT - NSC / 2); // first negative-frequency bin
  localparam logic [CW-1:0] LAST   = CW'(NFFT - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [3:0]    s_q, m_q;
  logic [3:0]    dec_s, dec_m;
  logic [DW-1:0] bank_re [NSC];
  logic [DW-1:0] bank_im [NSC];
  logic [DW-1:0] in_re_arr [NSC];
  logic [DW-1:0] in_im_arr [NSC];

  logic          accept, xfer;
  logic          in_map, hit;
  logic [3:0]    k, off;
  logic [CW-1:0] hi_diff;

  always_comb begin
    in_re_arr[0]  = in_rl0;   in_im_arr[0]  = in_img0;
    in_re_arr[1]  = in_rl1;   in_im_arr[1]  = in_img1;
    in_re_arr[2]  = in_rl2;   in_im_arr[2]  = in_img2;
    in_re_arr[3]  = in_rl3;   in_im_arr[3]  = in_img3;
    in_re_arr[4]  = in_rl4;   in_im_arr[4]  = in_img4;
    in_re_arr[5]  = in_rl5;   in_im_arr[5]  = in_img5;
    in_re_arr[6]  = in_rl6;   in_im_arr[6]  = in_img6;
    in_re_arr[7]  = in_rl7;   in_im_arr[7]  = in_img7;
    in_re_arr[8]  = in_rl8;   in_im_arr[8]  = in_img8;
    in_re_arr[9]  = in_rl9;   in_im_arr[9]  = in_img9;
    in_re_arr[10] = in_rl10;  in_im_arr[10] = in_img10;
    in_re_arr[11] = in_rl11;  in_im_arr[11] = in_img11;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == STREAM);
  assign accept    = in_ready && in_valid;
  assign xfer      = out_valid && out_ready;

  // FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = STREAM;
      STREAM:  if (out_ready && cnt_q == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ISC -> start subcarrier / tone count. m=0 for illegal values so nothing matches.
  always_comb begin
    dec_s = 4'd0;
    dec_m = 4'd0;
    if (ISC <= 5'd11) begin
      dec_s = ISC[3:0];
      dec_m = 4'd1;
    end else begin
      case (ISC)
        5'd12: begin dec_s = 4'd0; dec_m = 4'd3;  end
        5'd13: begin dec_s = 4'd3; dec_m = 4'd3;  end
        5'd14: begin dec_s = 4'd6; dec_m = 4'd3;  end
        5'd15: begin dec_s = 4'd9; dec_m = 4'd3;  end
        5'd16: begin dec_s = 4'd0; dec_m = 4'd6;  end
        5'd17: begin dec_s = 4'd6; dec_m = 4'd6;  end
        5'd18: begin dec_s = 4'd0; dec_m = 4'd12; end
        default: begin dec_s = 4'd0; dec_m = 4'd0; end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= '0;
      s_q     <= '0;
      m_q     <= '0;
      isc_err <= 1'b0;
      for (int i = 0; i < NSC; i++) begin
        bank_re[i] <= '0;
        bank_im[i] <= '0;
      end
    end else begin
      if (accept) begin
        cnt_q   <= '0;
        s_q     <= dec_s;
        m_q     <= dec_m;
        isc_err <= (ISC > 5'd18);
        for (int i = 0; i < NSC; i++) begin
          bank_re[i] <= in_re_arr[i];
          bank_im[i] <= in_im_arr[i];
        end
      end else if (xfer) begin
        cnt_q <= cnt_q + 1'b1;  // wraps to 0 after the last bin
      end
    end
  end

  // Bin -> subcarrier: low bins hold the upper half of the carrier, the top
  // bins (negative frequencies) hold the lower half.
  always_comb begin
    in_map  = 1'b0;
    k       = 4'd0;
    hi_diff = cnt_q - HI_MIN;
    if (cnt_q <= LO_MAX) begin
      in_map = 1'b1;
      k      = cnt_q[3:0] + 4'(NSC / 2);
    end else if (cnt_q >= HI_MIN) begin
      in_map = 1'b1;
      k      = hi_diff[3:0];
    end
  end

  assign off = k - s_q;
  assign hit = in_map && ({1'b0, k} >= {1'b0, s_q}) &&
               ({1'b0, k} < ({1'b0, s_q} + {1'b0, m_q}));

  assign out_idx  = cnt_q;
  assign out_last = out_valid && (cnt_q == LAST);
  assign out_re   = (out_valid && hit) ? bank_re[off] : '0;
  assign out_im   = (out_valid && hit) ? bank_im[off] : '0;

endmodule
